// File: rtl/ofm_collector.sv
// ofm_collector: gathers per-PE OFM bytes into ping-pong banks and drains them as packed words.
module ofm_collector #(
    parameter int NUM_PE = 16,
    parameter int DATA_W = 8,
    parameter int OUT_W  = 32,
    parameter int ADDR_W = 12
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [ADDR_W-1:0]        base_addr,
    input  logic [15:0]              num_batches,
    input  logic [NUM_PE*DATA_W-1:0] ofm_in,
    input  logic [NUM_PE-1:0]        valid_in,
    output logic                     in_ready,
    output logic                     wr_valid,
    input  logic                     wr_ready,
    output logic [OUT_W-1:0]         wr_data,
    output logic [ADDR_W-1:0]        wr_addr,
    output logic                     wr_last,
    output logic                     busy,
    output logic                     done,
    output logic                     overflow
);
    localparam int WORDS = NUM_PE * DATA_W / OUT_W;
    localparam int KW = WORDS > 1 ? $clog2(WORDS) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    typedef enum logic {D_IDLE, D_SEND} dstate_t;
    state_t                  state_q, state_d;
    dstate_t                 dstate_q, dstate_d;
    logic [KW-1:0]           k_q, k_d;
    logic [NUM_PE-1:0]       mask_q [2];
    logic [NUM_PE-1:0]       mask_d [2];
    logic [NUM_PE*DATA_W-1:0] data_q [2];
    logic [NUM_PE*DATA_W-1:0] data_d [2];
    logic [1:0]              full_q, full_d;
    logic                    fill_q, fill_d, drain_q, drain_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [15:0]             batch_q, batch_d;
    logic                    ovf_q, ovf_d;

    assign busy     = state_q == RUN;
    assign in_ready = busy && !full_q[fill_q];
    assign wr_valid = busy && dstate_q == D_SEND;
    assign wr_last  = wr_valid && k_q == KW'(WORDS - 1);
    assign wr_addr  = addr_q;
    assign wr_data  = wr_valid ? data_q[drain_q][OUT_W*int'(k_q) +: OUT_W] : '0;
    assign done     = state_q == DONE;
    assign overflow = ovf_q;

    always_comb begin
        state_d  = state_q;
        dstate_d = dstate_q;
        k_d      = k_q;
        mask_d   = mask_q;
        data_d   = data_q;
        full_d   = full_q;
        fill_d   = fill_q;
        drain_d  = drain_q;
        addr_d   = addr_q;
        batch_d  = batch_q;
        ovf_d    = ovf_q;
        for (int i = 0; i < NUM_PE; i++) begin
            if (valid_in[i]) begin
                if (in_ready && !mask_q[fill_q][i]) begin
                    mask_d[fill_q][i] = 1'b1;
                    data_d[fill_q][i*DATA_W +: DATA_W] = ofm_in[i*DATA_W +: DATA_W];
                end else begin
                    ovf_d = 1'b1;
                end
            end
        end
        // a bank is declared full one edge after its mask completes
        if (busy && &mask_q[fill_q] && !full_q[fill_q]) begin
            full_d[fill_q] = 1'b1;
            fill_d = !fill_q;
        end
        if (busy && dstate_q == D_IDLE && full_q[drain_q]) begin
            dstate_d = D_SEND;
            k_d = '0;
        end
        if (wr_valid && wr_ready) begin
            addr_d = addr_q + ADDR_W'(1);
            k_d = k_q + KW'(1);
            if (wr_last) begin
                mask_d[drain_q] = '0;
                full_d[drain_q] = 1'b0;
                drain_d  = !drain_q;
                batch_d  = batch_q != 16'd0 ? batch_q - 16'd1 : 16'd0;
                dstate_d = D_IDLE;
                state_d  = batch_q == 16'd1 ? DONE : RUN;
            end
        end
        if (state_q == IDLE && start) begin
            addr_d  = base_addr;
            batch_d = num_batches;
            ovf_d   = 1'b0;
            state_d = num_batches == 16'd0 ? DONE : RUN;
        end
        if (state_q == DONE) begin
            state_d  = IDLE;
            dstate_d = D_IDLE;
            k_d      = '0;
            mask_d   = '{default: '0};
            full_d   = '0;
            fill_d   = 1'b0;
            drain_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            dstate_q <= D_IDLE;
            k_q      <= '0;
            mask_q   <= '{default: '0};
            data_q   <= '{default: '0};
            full_q   <= '0;
            fill_q   <= 1'b0;
            drain_q  <= 1'b0;
            addr_q   <= '0;
            batch_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            dstate_q <= dstate_d;
            k_q      <= k_d;
            mask_q   <= mask_d;
            data_q   <= data_d;
            full_q   <= full_d;
            fill_q   <= fill_d;
            drain_q  <= drain_d;
            addr_q   <= addr_d;
            batch_q  <= batch_d;
            ovf_q    <= ovf_d;
        end
    end
endmodule

// File: doc/ofm_collector.md
Name: ofm_collector

Overview:
- Sits at the output end of the PE cluster and consumes the 16 per-PE 8-bit OFM results together with their per-PE valid bits.
- Gathers one complete batch (one byte from every PE) into a ping-pong bank pair.
- Drains each full bank as packed 32-bit words to the OFM buffer write port using a valid/ready handshake and an auto-incrementing address.
- Counts batches and pulses done after a programmed number of batches.

Parameters:
NUM_PE, 16, number of PE results per batch (multiple of 4)
DATA_W, 8, width of one OFM result
OUT_W, 32, write-port word width; WORDS = NUM_PE*DATA_W/OUT_W (default 4)
ADDR_W, 12, OFM buffer address width

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
start  in  1  one-cycle pulse: load base_addr and num_batches, enter RUN
base_addr  in  ADDR_W  first write address
num_batches  in  16  batches to collect; 0 means done immediately
ofm_in  in  NUM_PE*DATA_W  OFM of PE i at bits [8i+7:8i]
valid_in  in  NUM_PE  per-PE result strobe
in_ready  out  1  at least one bank can accept bytes
wr_valid  out  1  write word valid
wr_ready  in  1  buffer accepts word
wr_data  out  OUT_W  packed word
wr_addr  out  ADDR_W  word address
wr_last  out  1  last word of a batch
busy  out  1  state is RUN
done  out  1  one-cycle pulse when the final batch's last word is accepted
overflow  out  1  sticky error flag, cleared by reset or start

Behaviour:
- Reset values: in_ready=0, wr_valid=0, wr_data=0, wr_addr=0, wr_last=0, busy=0, done=0, overflow=0. Bank masks are cleared, the fill pointer and drain pointer are both 0, and the control FSM is in IDLE.
- Control FSM IDLE -> RUN on start:
  - start loads addr counter = base_addr and batch counter = num_batches.
  - If num_batches=0, go to DONE instead of RUN.
- Control FSM RUN -> DONE when the final batch's wr_last word handshakes.
- Control FSM DONE -> IDLE after one cycle; done=1 only during DONE.
- start is ignored outside IDLE.
- In IDLE, in_ready=0, and any valid_in bit sets overflow.
- Capture (RUN only):
  - When valid_in[i]=1 and fill bank byte i is not yet captured, latch ofm_in byte i and set mask bit i.
  - Bits may arrive in any cycles, in any order, and several in the same cycle.
  - A valid_in[i] for a byte already captured in the fill bank sets overflow; the existing byte is kept.
  - When the mask becomes all ones, including within the same cycle the last bits arrive, the bank is marked full on the next edge and the fill pointer toggles.
- in_ready = RUN and the fill bank is not full, taken from registered state.
- valid_in while in_ready=0 sets overflow and the data is dropped.
- Drain FSM: states D_IDLE and D_SEND, with word index k in 0..WORDS-1.
  - D_IDLE -> D_SEND when the drain bank is full.
  - The last byte is captured at edge N; the bank becomes full at N+1; wr_valid is first high after edge N+2.
  - Word k = bytes 4k..4k+3, with byte 4k in [7:0] and byte 4k+3 in [31:24].
  - wr_data, wr_addr and wr_last stay stable while wr_valid=1 and wr_ready=0.
  - On each handshake, wr_addr increments, wrapping modulo 2^ADDR_W, and k increments.
  - wr_last=1 only when k=WORDS-1.
  - On the last-word handshake: clear the bank mask and full flag, toggle the drain pointer, decrement the batch counter, and return to D_IDLE.
  - If the other bank is already full, go straight back to D_SEND (2-cycle turnaround).
- Throughput: with wr_ready held at 1, one word per cycle.
- Simultaneous events: filling one bank and freeing the other in the same cycle both take effect. in_ready reflects the freed bank from the following cycle.
- Batch counter reaches 0 while partial bytes exist in the fill bank: bytes are discarded on DONE and masks are cleared.
- reset mid-operation: all state returns to reset values within one edge, and an in-flight word is abandoned.
- Widths: batch counter is 16-bit with no wrap below 0. Address arithmetic is unsigned, modulo 2^ADDR_W.

Test Plan:
- Single batch: start base_addr=0x010, num_batches=1, then all 16 valid_in bits in one cycle with byte i = 0x10+i, wr_ready=1.
  -> words 0x13121110@0x010, 0x17161514@0x011, 0x1B1A1918@0x012, 0x1F1E1D1C@0x013.
  -> wr_last on the 4th word; done pulses once the cycle after the 4th word; busy=0 afterwards.
- Staggered arrival: num_batches=1, PE bytes delivered one per cycle in reverse order 15..0.
  -> no wr_valid until 2 cycles after PE0's strobe; same word packing as scenario 1.
- Backpressure: wr_ready=0 for 5 cycles after wr_valid rises.
  -> wr_data and wr_addr held constant for 5 cycles; the second batch fills bank 1.
  -> a third batch sees in_ready=0; asserting valid_in then sets overflow=1.
- Back-to-back: num_batches=3, a full batch every 4 cycles, wr_ready=1.
  -> 12 words at base..base+11 with wr_last on words 4, 8 and 12; overflow stays 0; done after word 12.
- Address wrap and duplicate strobe: base_addr=0xFFE, one batch with PE3 strobed twice (second strobe data 0xAA).
  -> addresses 0xFFE, 0xFFF, 0x000, 0x001; byte 3 keeps its first value; overflow=1.
- Mid-operation reset: reset asserted during word 2 of the drain.
  -> next cycle wr_valid=0, busy=0, overflow=0; a new start works normally.
